arb_mux: RTL and testbench

ARB_MUX -- requirements
Module: arb_mux

---
 rtl/arb_mux_pkg.sv | 10 +
 rtl/rr_arbiter.sv | 50 +++++
 rtl/arb_mux.sv | 79 +++++++
 tb/tb_arb_mux.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_mux_pkg.sv
// Shared defaults and arbitration-mode constants for the arb_mux slice.
package arb_mux_pkg;

  localparam int unsigned WIDTH_DEF = 32;
  localparam int unsigned N_DEF     = 4;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

endpackage : arb_mux_pkg

// File: rtl/rr_arbiter.sv
// Grant logic: round-robin pointer plus wrap-around first-set search.
// In fixed-priority mode the search starts at 0 and the pointer is frozen.
module rr_arbiter
  import arb_mux_pkg::*;
#(
  parameter int unsigned N    = N_DEF,
  parameter int unsigned SELW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mode,
  input  logic [N-1:0]    req,
  input  logic            accept,
  output logic            gnt_valid_c,
  output logic [SELW-1:0] gnt_idx_c
);

  logic [SELW-1:0] ptr;
  logic [SELW-1:0] base_c;
  logic [SELW-1:0] cand_c;
  logic [SELW-1:0] ptr_nxt_c;

  // First requester at or above the search base, wrapping from N-1 to 0
  always_comb begin
    gnt_valid_c = 1'b0;
    gnt_idx_c   = '0;
    cand_c      = '0;
    base_c      = (mode == MODE_FIXED) ? '0 : ptr;
    for (int unsigned i = 0; i < N; i++) begin
      cand_c = SELW'((32'(base_c) + i) % N);
      if (!gnt_valid_c && req[cand_c]) begin
        gnt_valid_c = 1'b1;
        gnt_idx_c   = cand_c;
      end
    end
  end

  // Explicit wrap keeps non-power-of-two N correct
  assign ptr_nxt_c = (gnt_idx_c == SELW'(N - 1)) ? '0 : gnt_idx_c + SELW'(1);

  // Pointer advances past the winner only on an accepted round-robin transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (accept && (mode == MODE_RR)) begin
      ptr <= ptr_nxt_c;
    end
  end

endmodule : rr_arbiter

// File: rtl/arb_mux.sv
// N-to-1 arbitrated mux with a single registered output stage.
// The output register reloads whenever it is empty or being drained, so a
// steady stream moves one word per cycle with no bubbles.
module arb_mux
  import arb_mux_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned N     = N_DEF,
  parameter int unsigned SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_sel,
  input  logic               out_ready
);

  logic            load_en_c;
  logic            accept_c;
  logic            gnt_valid_c;
  logic [SELW-1:0] gnt_idx_c;
  logic [WIDTH-1:0] sel_data_c;

  assign load_en_c = !out_valid || out_ready;
  // rst_n gating keeps every ready low while reset is held
  assign accept_c  = rst_n && load_en_c && gnt_valid_c;

  rr_arbiter #(
    .N    (N),
    .SELW (SELW)
  ) u_rr_arbiter (
    .clk         (clk),
    .rst_n       (rst_n),
    .mode        (mode),
    .req         (in_valid),
    .accept      (accept_c),
    .gnt_valid_c (gnt_valid_c),
    .gnt_idx_c   (gnt_idx_c)
  );

  // One-hot ready to the granted channel only when the output can take it
  always_comb begin
    in_ready = '0;
    if (accept_c) begin
      in_ready[gnt_idx_c] = 1'b1;
    end
  end

  // Select the granted channel's word
  always_comb begin
    sel_data_c = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (gnt_idx_c == SELW'(i)) begin
        sel_data_c = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Output register: load on accept, clear valid on drain, else hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (accept_c) begin
      out_valid <= 1'b1;
      out_data  <= sel_data_c;
      out_sel   <= gnt_idx_c;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule : arb_mux

// File: tb/tb_arb_mux.sv
// Scoreboard bench for arb_mux: a reference model predicts grants and pushes
// expected words; a monitor pops and compares whatever the DUT presents.
module tb_arb_mux;

  localparam int unsigned W  = 32;
  localparam int unsigned NC = 4;

  typedef struct packed {
    logic [W-1:0] data;
    logic [1:0]   sel;
  } exp_t;

  logic            clk;
  logic            rst_n;
  logic            mode;
  logic [NC-1:0]   in_valid;
  logic [NC*W-1:0] in_data;
  logic [NC-1:0]   in_ready;
  logic            out_valid;
  logic [W-1:0]    out_data;
  logic [1:0]      out_sel;
  logic            out_ready;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];
  int   sel_log[$];

  // model state
  bit   m_valid = 1'b0;
  int   m_ptr   = 0;

  arb_mux #(
    .WIDTH (W),
    .N     (NC),
    .SELW  (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: evaluated mid-cycle on the inputs that the next edge will see
  always @(negedge clk) begin
    bit         found;
    bit         load;
    int         g;
    int         c;
    logic [3:0] er;
    if (!rst_n) begin
      check("reset_in_ready", 64'(in_ready), 64'(0));
      m_valid = 1'b0;
      m_ptr   = 0;
      exp_q.delete();
    end else begin
      check("out_valid", 64'(out_valid), 64'(m_valid));
      load  = !m_valid || out_ready;
      found = 1'b0;
      g     = 0;
      for (int k = 0; k < NC; k++) begin
        c = ((mode ? 0 : m_ptr) + k) % NC;
        if (!found && in_valid[c]) begin
          found = 1'b1;
          g     = c;
        end
      end
      er = '0;
      if (load && found) er[g] = 1'b1;
      check("in_ready", 64'(in_ready), 64'(er));
      if (load && found) begin
        exp_q.push_back('{data: in_data[g*W +: W], sel: 2'(g)});
        m_valid = 1'b1;
        if (mode == 1'b0) m_ptr = (g + 1) % NC;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // Monitor: every presented word must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL out_unexpected: got word 0x%0h sel %0d, expected no word", out_data, out_sel);
      end else begin
        check("out_data", 64'(out_data), 64'(exp_q[0].data));
        check("out_sel", 64'(out_sel), 64'(exp_q[0].sel));
        if (out_ready) begin
          sel_log.push_back(int'(out_sel));
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // Apply inputs for one cycle, just after the active edge
  task automatic cyc(input logic m, input logic [3:0] v, input logic r);
    @(posedge clk);
    #1;
    mode      = m;
    in_valid  = v;
    out_ready = r;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cyc(mode, 4'b0000, 1'b1);
    @(negedge clk);
    #1;
  endtask

  // Asynchronous reset with all channels requesting, then release
  task automatic apply_reset(input logic [3:0] rel_valid);
    in_valid = 4'b1111;
    rst_n    = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));
    check("rst_out_sel", 64'(out_sel), 64'(0));
    check("rst_in_ready_async", 64'(in_ready), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    in_valid = rel_valid;
    rst_n    = 1'b1;
    sel_log.delete();
  endtask

  initial begin
    rst_n     = 1'b0;
    mode      = 1'b0;
    in_valid  = 4'b1111;
    out_ready = 1'b0;
    in_data   = {32'h44, 32'h33, 32'h22, 32'h11};
    #3;
    check("init_out_valid", 64'(out_valid), 64'(0));
    check("init_out_data", 64'(out_data), 64'(0));
    check("init_out_sel", 64'(out_sel), 64'(0));
    check("init_in_ready", 64'(in_ready), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    in_valid = 4'b0000;
    rst_n    = 1'b1;

    // Round-robin fairness
    sel_log.delete();
    for (int i = 0; i < 5; i++) cyc(1'b0, 4'b1111, 1'b1);
    drain(2);
    check("rr_count", 64'(sel_log.size()), 64'(5));
    if (sel_log.size() == 5) begin
      check("rr_sel0", 64'(sel_log[0]), 64'(0));
      check("rr_sel1", 64'(sel_log[1]), 64'(1));
      check("rr_sel2", 64'(sel_log[2]), 64'(2));
      check("rr_sel3", 64'(sel_log[3]), 64'(3));
      check("rr_sel4", 64'(sel_log[4]), 64'(0));
    end

    // Fixed priority with channels 1 and 3 requesting
    sel_log.delete();
    for (int i = 0; i < 6; i++) cyc(1'b1, 4'b1010, 1'b1);
    drain(2);
    check("fix_count", 64'(sel_log.size()), 64'(6));
    foreach (sel_log[i]) check("fix_sel", 64'(sel_log[i]), 64'(1));

    // Wrap from pointer 3 with sparse requests
    apply_reset(4'b0000);
    cyc(1'b0, 4'b0100, 1'b1);
    cyc(1'b0, 4'b0101, 1'b1);
    cyc(1'b0, 4'b0101, 1'b1);
    drain(2);
    check("wrap_count", 64'(sel_log.size()), 64'(3));
    if (sel_log.size() == 3) begin
      check("wrap_sel0", 64'(sel_log[0]), 64'(2));
      check("wrap_sel1", 64'(sel_log[1]), 64'(0));
      check("wrap_sel2", 64'(sel_log[2]), 64'(2));
    end

    // Backpressure: hold 0xDEADBEEF for 5 cycles, then stream the next word
    in_data[31:0] = 32'hDEADBEEF;
    cyc(1'b0, 4'b0001, 1'b1);
    cyc(1'b0, 4'b0001, 1'b0);
    in_data[31:0] = 32'hCAFEF00D;
    for (int i = 0; i < 4; i++) cyc(1'b0, 4'b0001, 1'b0);
    @(negedge clk);
    #1;
    check("bp_hold_data", 64'(out_data), 64'(32'hDEADBEEF));
    check("bp_hold_valid", 64'(out_valid), 64'(1));
    check("bp_in_ready", 64'(in_ready), 64'(0));
    cyc(1'b0, 4'b0001, 1'b1);
    cyc(1'b0, 4'b0000, 1'b1);
    @(negedge clk);
    #1;
    check("bp_next_valid", 64'(out_valid), 64'(1));
    check("bp_next_data", 64'(out_data), 64'(32'hCAFEF00D));
    drain(2);

    // Reset in the middle of a round-robin burst
    in_data = {32'h44, 32'h33, 32'h22, 32'h11};
    apply_reset(4'b0000);
    for (int i = 0; i < 3; i++) cyc(1'b0, 4'b1111, 1'b1);
    @(posedge clk);
    #2;
    check("mid_sel_before", 64'(out_sel), 64'(2));
    check("mid_valid_before", 64'(out_valid), 64'(1));
    apply_reset(4'b1111);
    cyc(1'b0, 4'b1111, 1'b1);
    drain(2);
    check("mid_after_nonempty", 64'(sel_log.size() > 0), 64'(1));
    if (sel_log.size() > 0) check("mid_first_sel", 64'(sel_log[0]), 64'(0));

    // Randomized traffic with mode changes and random backpressure
    for (int i = 0; i < 600; i++) begin
      logic m;
      m = mode;
      if ($urandom_range(0, 15) == 0) m = ~m;
      cyc(m, 4'($urandom), ($urandom_range(0, 3) != 0));
      for (int c = 0; c < NC; c++) in_data[c*W +: W] = $urandom;
    end
    drain(3);
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_arb_mux
